// File: rtl/seven_segment_pkg.sv
// seven_segment_pkg: segment bit indices, hex glyph table and default
// scan prescale shared by the seven-segment scanner and its decoder.
package seven_segment_pkg;

   localparam int SEG_A = 6;
   localparam int SEG_B = 5;
   localparam int SEG_C = 4;
   localparam int SEG_D = 3;
   localparam int SEG_E = 2;
   localparam int SEG_F = 1;
   localparam int SEG_G = 0;

   localparam logic [6:0] SEG_BLANK = 7'b0000000;

   localparam logic [6:0] HEX_0 = 7'b1111110;
   localparam logic [6:0] HEX_1 = 7'b0110000;
   localparam logic [6:0] HEX_2 = 7'b1101101;
   localparam logic [6:0] HEX_3 = 7'b1111001;
   localparam logic [6:0] HEX_4 = 7'b0110011;
   localparam logic [6:0] HEX_5 = 7'b1011011;
   localparam logic [6:0] HEX_6 = 7'b1011111;
   localparam logic [6:0] HEX_7 = 7'b1110000;
   localparam logic [6:0] HEX_8 = 7'b1111111;
   localparam logic [6:0] HEX_9 = 7'b1111011;
   localparam logic [6:0] HEX_A = 7'b1110111;
   localparam logic [6:0] HEX_B = 7'b0011111;
   localparam logic [6:0] HEX_C = 7'b1001110;
   localparam logic [6:0] HEX_D = 7'b0111101;
   localparam logic [6:0] HEX_E = 7'b1001111;
   localparam logic [6:0] HEX_F = 7'b1000111;

   localparam int DEFAULT_PRESCALE = 50000;

endpackage

// File: rtl/seven_segment_hex_decoder.sv
// seven_segment_hex_decoder: maps one nibble to an active-high A..G
// segment pattern (bit 6 = A, bit 0 = G).
module seven_segment_hex_decoder
   import seven_segment_pkg::*;
(
   input  logic [3:0] nib,
   output logic [6:0] seg
);

   // Full 16-code glyph lookup.
   always_comb begin
      seg = SEG_BLANK;
      unique case (nib)
         4'h0: seg = HEX_0;
         4'h1: seg = HEX_1;
         4'h2: seg = HEX_2;
         4'h3: seg = HEX_3;
         4'h4: seg = HEX_4;
         4'h5: seg = HEX_5;
         4'h6: seg = HEX_6;
         4'h7: seg = HEX_7;
         4'h8: seg = HEX_8;
         4'h9: seg = HEX_9;
         4'hA: seg = HEX_A;
         4'hB: seg = HEX_B;
         4'hC: seg = HEX_C;
         4'hD: seg = HEX_D;
         4'hE: seg = HEX_E;
         4'hF: seg = HEX_F;
      endcase
   end

endmodule

// File: rtl/seven_segment_scanner.sv
// seven_segment_scanner: time-multiplexed, double-buffered hex display
// driver. Define SEVEN_SEGMENT_SCANNER_LZB_EN for leading-zero blanking.
module seven_segment_scanner
   import seven_segment_pkg::*;
#(
   parameter int NUM_DIGITS = 4,
   parameter int PRESCALE   = DEFAULT_PRESCALE
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic [4*NUM_DIGITS-1:0] value,
   input  logic                    load,
   input  logic                    enable,
   output logic [6:0]              segments,
   output logic [NUM_DIGITS-1:0]   digit_sel,
   output logic                    frame_start,
   output logic                    pending
);

   localparam int W  = 4 * NUM_DIGITS;
   localparam int CW = $clog2(PRESCALE);
   localparam int IW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

   localparam logic [CW-1:0]         CMAX = CW'(PRESCALE - 1);
   localparam logic [IW-1:0]         IMAX = IW'(NUM_DIGITS - 1);
   localparam logic [NUM_DIGITS-1:0] ONE  = NUM_DIGITS'(1);

   logic [CW-1:0] cnt;
   logic [IW-1:0] idx;
   logic [IW-1:0] nidx;
   logic          tick;
   logic          wrap;
   logic          swap;
   logic [W-1:0]  pend_reg;
   logic [W-1:0]  disp_reg;
   logic [W-1:0]  disp_nxt;
   logic          pend_valid;
   logic [3:0]    nib;
   logic [6:0]    seg_dec;
   logic [6:0]    seg_nxt;

   // Slot timing, frame wrap and the display data seen by the next slot.
   always_comb begin
      tick     = (cnt == CMAX);
      wrap     = tick && (idx == IMAX);
      swap     = wrap && pend_valid;
      nidx     = (idx == IMAX) ? '0 : idx + 1'b1;
      disp_nxt = swap ? pend_reg : disp_reg;
      nib      = disp_nxt[{nidx, 2'b00} +: 4];
   end

   seven_segment_hex_decoder u_dec (
      .nib (nib),
      .seg (seg_dec)
   );

`ifdef SEVEN_SEGMENT_SCANNER_LZB_EN
   logic [W-1:0] upper;

   // Blank a non-zero digit when it and every higher nibble are zero.
   always_comb begin
      upper   = disp_nxt >> {nidx, 2'b00};
      seg_nxt = ((nidx != '0) && (upper == '0)) ? SEG_BLANK : seg_dec;
   end
`else
   assign seg_nxt = seg_dec;
`endif

   // Prescaler and scan index.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt <= '0;
         idx <= IMAX;
      end else if (tick) begin
         cnt <= '0;
         idx <= nidx;
      end else begin
         cnt <= cnt + 1'b1;
      end
   end

   // Pending/display double buffer; swaps only at a frame boundary.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pend_reg   <= '0;
         pend_valid <= 1'b0;
         disp_reg   <= '0;
      end else begin
         if (load) begin
            pend_reg   <= value;
            pend_valid <= 1'b1;
         end else if (swap) begin
            pend_valid <= 1'b0;
         end
         if (swap) begin
            disp_reg <= pend_reg;
         end
      end
   end

   // Registered pin drivers; enable low kills digit_sel immediately.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         segments    <= SEG_BLANK;
         digit_sel   <= '0;
         frame_start <= 1'b0;
      end else if (tick) begin
         segments    <= seg_nxt;
         digit_sel   <= enable ? (ONE << nidx) : '0;
         frame_start <= (nidx == '0);
      end else begin
         frame_start <= 1'b0;
         if (!enable) begin
            digit_sel <= '0;
         end
      end
   end

   assign pending = pend_valid;

endmodule

// File: tb/tb_seven_segment_scanner.sv
// tb_seven_segment_scanner: directed scenarios with a cycle-count based
// reference model compared every cycle, plus literal glyph checks.
module tb_seven_segment_scanner;

   localparam int N = 4;
   localparam int P = 4;

`ifdef SEVEN_SEGMENT_SCANNER_LZB_EN
   localparam logic [6:0] Z = 7'b0000000;
`else
   localparam logic [6:0] Z = 7'b1111110;
`endif

   logic          clk = 1'b0;
   logic          rst_n;
   logic [15:0]   value;
   logic          load;
   logic          enable;
   logic [6:0]    segments;
   logic [3:0]    digit_sel;
   logic          frame_start;
   logic          pending;

   int n_cmp = 0;
   int n_err = 0;

   seven_segment_scanner #(
      .NUM_DIGITS (N),
      .PRESCALE   (P)
   ) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .value       (value),
      .load        (load),
      .enable      (enable),
      .segments    (segments),
      .digit_sel   (digit_sel),
      .frame_start (frame_start),
      .pending     (pending)
   );

   always #5 clk = ~clk;

   logic [6:0] lut [16] = '{
      7'b1111110, 7'b0110000, 7'b1101101, 7'b1111001,
      7'b0110011, 7'b1011011, 7'b1011111, 7'b1110000,
      7'b1111111, 7'b1111011, 7'b1110111, 7'b0011111,
      7'b1001110, 7'b0111101, 7'b1001111, 7'b1000111
   };

   function automatic logic [6:0] show(logic [15:0] d, int s);
      logic [15:0] hi;
      hi = d >> (4 * s);
`ifdef SEVEN_SEGMENT_SCANNER_LZB_EN
      if (s > 0 && hi == 16'h0) return 7'b0000000;
`endif
      return lut[hi[3:0]];
   endfunction

   task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // Reference model: k counts clocks since reset release; slot t
   // begins at the clock ending cycle P*(t+1).
   int          k;
   int          slot;
   logic [15:0] m_pend;
   logic [15:0] m_disp;
   bit          m_pv;
   logic [6:0]  e_seg;
   logic [3:0]  e_sel;
   bit          e_fs;

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         k = 0; m_pend = 0; m_disp = 0; m_pv = 0;
         e_seg = 0; e_sel = 0; e_fs = 0;
      end else begin
         if ((k % P) == P - 1) begin
            slot = (k / P) % N;
            if (slot == 0 && m_pv) begin
               m_disp = m_pend;
               m_pv   = 0;
            end
            e_seg = show(m_disp, slot);
            e_sel = enable ? 4'(1 << slot) : 4'b0;
            e_fs  = (slot == 0);
         end else begin
            e_fs = 0;
            if (!enable) e_sel = 0;
         end
         if (load) begin
            m_pend = value;
            m_pv   = 1;
         end
         k++;
      end
   end

   always @(negedge clk) begin
      chk("segments", segments, e_seg);
      chk("digit_sel", digit_sel, e_sel);
      chk("frame_start", frame_start, e_fs);
      chk("pending", pending, m_pv);
   end

   task automatic goto(int e);
      int guard;
      guard = 0;
      if (k > e) begin
         n_cmp++;
         n_err++;
         $display("FAIL sched: at %0d target %0d", k, e);
      end
      while (k < e && guard < 1000) begin
         @(negedge clk);
         guard++;
      end
      if (k < e) begin
         n_cmp++;
         n_err++;
         $display("FAIL timeout: at %0d target %0d", k, e);
      end
   endtask

   task automatic do_load(logic [15:0] v);
      value = v;
      load  = 1'b1;
      @(negedge clk);
      load  = 1'b0;
   endtask

   initial begin
      rst_n = 1'b0; load = 1'b0; enable = 1'b1; value = '0;
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      chk("rst_seg", segments, 7'b0000000);
      chk("rst_sel", digit_sel, 4'b0000);
      chk("rst_fs", frame_start, 1'b0);
      chk("rst_pend", pending, 1'b0);
      goto(3);
      chk("pre_tick_sel", digit_sel, 4'b0000);
      goto(4);
      chk("tick1_sel", digit_sel, 4'b0001);
      chk("tick1_seg", segments, 7'b1111110);
      chk("tick1_fs", frame_start, 1'b1);

      do_load(16'h12AF);
      chk("load_pend", pending, 1'b1);
      goto(20);
      chk("12AF_d0", segments, 7'b1000111);
      chk("12AF_pend", pending, 1'b0);
      goto(24); chk("12AF_d1", segments, 7'b1110111);
      goto(28); chk("12AF_d2", segments, 7'b1101101);
      goto(32); chk("12AF_d3", segments, 7'b0110000);

      do_load(16'h8888);
      goto(40);
      do_load(16'h0000);
      goto(44); chk("tear_d2", segments, 7'b1111111);
      goto(48); chk("tear_d3", segments, 7'b1111111);
      goto(52); chk("tear_next_d0", segments, 7'b1111110);

      goto(53); do_load(16'h1111);
      goto(57); do_load(16'h2222);
      goto(67); do_load(16'h3333);
      chk("dbl_d0", segments, 7'b1101101);
      chk("wrapload_pend", pending, 1'b1);
      goto(72); chk("dbl_d1", segments, 7'b1101101);
      goto(84);
      chk("3333_d0", segments, 7'b1111001);
      chk("3333_pend", pending, 1'b0);

      goto(86); enable = 1'b0;
      goto(87); chk("en_off_sel", digit_sel, 4'b0000);
      goto(88); chk("en_off_seg", segments, 7'b1111001);
      goto(90); enable = 1'b1;
      goto(91); chk("en_wait_sel", digit_sel, 4'b0000);
      goto(92); chk("en_on_sel", digit_sel, 4'b0100);

      goto(93); do_load(16'h5555);
      #2 rst_n = 1'b0;
      #1;
      chk("mid_rst_seg", segments, 7'b0000000);
      chk("mid_rst_sel", digit_sel, 4'b0000);
      chk("mid_rst_pend", pending, 1'b0);
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      goto(4);
      chk("post_rst_seg", segments, 7'b1111110);

      goto(5); do_load(16'h0005);
      goto(20); chk("lzb5_d0", segments, 7'b1011011);
      goto(21); do_load(16'h0500);
      goto(24); chk("lzb5_d1", segments, Z);
      goto(28); chk("lzb5_d2", segments, Z);
      goto(32); chk("lzb5_d3", segments, Z);
      goto(36); chk("lzb500_d0", segments, 7'b1111110);
      goto(37); do_load(16'h0000);
      goto(40); chk("lzb500_d1", segments, 7'b1111110);
      goto(44); chk("lzb500_d2", segments, 7'b1011011);
      goto(48); chk("lzb500_d3", segments, Z);
      goto(52); chk("lzb0_d0", segments, 7'b1111110);
      goto(56); chk("lzb0_d1", segments, Z);
      goto(60);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
